// File: rtl/norm_arbiter.sv
// Two-requester round-robin front end for a single shared floating-point normalizer.
// The winner's operands are captured, normalized in one cycle, and the result is held until accepted.
module norm_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic [23:0] MANT0,
  input  logic        OF0,
  input  logic [7:0]  EXP0,
  input  logic        SIGN0,
  input  logic        REQ1,
  input  logic [23:0] MANT1,
  input  logic        OF1,
  input  logic [7:0]  EXP1,
  input  logic        SIGN1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_ID,
  output logic        OUT_SIGN,
  output logic [7:0]  OUT_EXP,
  output logic [22:0] OUT_MANT,
  output logic        OUT_ZERO,
  output logic        OUT_OVF,
  output logic        OUT_UNF,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [23:0] op_mant_q, op_mant_d;
  logic        op_of_q, op_of_d;
  logic [7:0]  op_exp_q, op_exp_d;
  logic        op_sign_q, op_sign_d;
  logic        op_id_q, op_id_d;
  logic        out_valid_q, out_valid_d;
  logic        out_id_q, out_id_d;
  logic        out_sign_q, out_sign_d;
  logic [7:0]  out_exp_q, out_exp_d;
  logic [22:0] out_mant_q, out_mant_d;
  logic        out_zero_q, out_zero_d;
  logic        out_ovf_q, out_ovf_d;
  logic        out_unf_q, out_unf_d;

  logic        win;
  logic [4:0]  lz;
  logic [23:0] shifted;
  logic [22:0] norm_mant;
  logic [9:0]  e_val;
  logic        res_zero, res_ovf, res_unf;
  logic [7:0]  res_exp;
  logic [22:0] res_mant;

  // Normalizer datapath on the captured operand; e_val is two's complement, bit 9 is the sign.
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (op_mant_q[i]) lz = 5'(23 - i);
    end
    shifted = op_mant_q << lz;
    if (op_of_q) begin
      norm_mant = op_mant_q[23:1];
      e_val     = {2'b00, op_exp_q} + 10'd1;
    end else begin
      norm_mant = shifted[22:0];
      e_val     = {2'b00, op_exp_q} - {5'd0, lz};
    end
    res_zero = 1'b0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    res_exp  = 8'h00;
    res_mant = 23'd0;
    if (!op_of_q && op_mant_q == 24'd0) begin
      res_zero = 1'b1;
    end else if (!e_val[9] && e_val >= 10'd255) begin
      res_ovf = 1'b1;
      res_exp = 8'hFF;
    end else if (e_val[9] || e_val == 10'd0) begin
      res_unf = 1'b1;
    end else begin
      res_exp  = e_val[7:0];
      res_mant = norm_mant;
    end
  end

  // Next-state logic: ties go to the requester that was not served last.
  always_comb begin
    win         = (REQ0 && REQ1) ? ~last_q : REQ1;
    state_d     = state_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    op_mant_d   = op_mant_q;
    op_of_d     = op_of_q;
    op_exp_d    = op_exp_q;
    op_sign_d   = op_sign_q;
    op_id_d     = op_id_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_mant_d  = out_mant_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          last_d    = win;
          op_id_d   = win;
          gnt0_d    = ~win;
          gnt1_d    = win;
          op_mant_d = win ? MANT1 : MANT0;
          op_of_d   = win ? OF1   : OF0;
          op_exp_d  = win ? EXP1  : EXP0;
          op_sign_d = win ? SIGN1 : SIGN0;
          state_d   = NORM;
        end
      end
      NORM: begin
        out_valid_d = 1'b1;
        out_id_d    = op_id_q;
        out_sign_d  = op_sign_q;
        out_exp_d   = res_exp;
        out_mant_d  = res_mant;
        out_zero_d  = res_zero;
        out_ovf_d   = res_ovf;
        out_unf_d   = res_unf;
        state_d     = HOLD;
      end
      HOLD: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset seeds last_q to 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      op_mant_q   <= 24'd0;
      op_of_q     <= 1'b0;
      op_exp_q    <= 8'h00;
      op_sign_q   <= 1'b0;
      op_id_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= 8'h00;
      out_mant_q  <= 23'd0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      op_mant_q   <= op_mant_d;
      op_of_q     <= op_of_d;
      op_exp_q    <= op_exp_d;
      op_sign_q   <= op_sign_d;
      op_id_q     <= op_id_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_mant_q  <= out_mant_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
    end
  end

  assign GNT0      = gnt0_q;
  assign GNT1      = gnt1_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_ID    = out_id_q;
  assign OUT_SIGN  = out_sign_q;
  assign OUT_EXP   = out_exp_q;
  assign OUT_MANT  = out_mant_q;
  assign OUT_ZERO  = out_zero_q;
  assign OUT_OVF   = out_ovf_q;
  assign OUT_UNF   = out_unf_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_norm_arbiter.sv
// Bench for norm_arbiter: directed corner cases followed by random traffic
// checked against a arithmetic normalization model and a round-robin pointer.
module tb_norm_arbiter;

  typedef struct packed {
    logic        zero;
    logic        ovf;
    logic        unf;
    logic [7:0]  e;
    logic [22:0] m;
  } res_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [23:0] mant0 = '0, mant1 = '0;
  logic        of0 = 1'b0, of1 = 1'b0;
  logic [7:0]  exp0 = '0, exp1 = '0;
  logic        sign0 = 1'b0, sign1 = 1'b0;
  logic        outReady = 1'b1;
  logic        gnt0, gnt1, outValid, outId, outSign, outZero, outOvf, outUnf, busy;
  logic [7:0]  outExp;
  logic [22:0] outMant;

  int nAsserts = 0;
  int nFails = 0;

  norm_arbiter dut (
    .CLK(clock), .RST(reset),
    .REQ0(req0), .MANT0(mant0), .OF0(of0), .EXP0(exp0), .SIGN0(sign0),
    .REQ1(req1), .MANT1(mant1), .OF1(of1), .EXP1(exp1), .SIGN1(sign1),
    .GNT0(gnt0), .GNT1(gnt1),
    .OUT_VALID(outValid), .OUT_READY(outReady), .OUT_ID(outId), .OUT_SIGN(outSign),
    .OUT_EXP(outExp), .OUT_MANT(outMant),
    .OUT_ZERO(outZero), .OUT_OVF(outOvf), .OUT_UNF(outUnf), .BUSY(busy)
  );

  always #5 clock = ~clock;

  function automatic res_t mkRes(input logic z, input logic o, input logic u,
                                 input logic [7:0] e, input logic [22:0] m);
    res_t r;
    r.zero = z; r.ovf = o; r.unf = u; r.e = e; r.m = m;
    return r;
  endfunction

  // Normalization rules written directly in integer arithmetic.
  function automatic res_t refNorm(input logic [23:0] mant, input logic of, input logic [7:0] ex);
    res_t        r;
    int          e;
    int          l;
    logic [23:0] m;
    r = '0;
    if (of) begin
      m = mant >> 1;
      e = int'(ex) + 1;
      r.m = m[22:0];
    end else if (mant == 24'd0) begin
      r.zero = 1'b1;
      return r;
    end else begin
      m = mant;
      l = 0;
      while (m < 24'h800000) begin
        m = m * 2;
        l++;
      end
      e = int'(ex) - l;
      r.m = m[22:0];
    end
    if (e >= 255) begin
      r.ovf = 1'b1; r.e = 8'hFF; r.m = '0;
    end else if (e <= 0) begin
      r.unf = 1'b1; r.e = 8'h00; r.m = '0;
    end else begin
      r.e = 8'(e);
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic req, input logic [23:0] mant,
                               input logic of, input logic [7:0] ex, input logic sign);
    if (id == 0) begin
      req0 = req; mant0 = mant; of0 = of; exp0 = ex; sign0 = sign;
    end else begin
      req1 = req; mant1 = mant; of1 = of; exp1 = ex; sign1 = sign;
    end
  endtask

  task automatic waitGrant(input int expId);
    int lat;
    lat = 0;
    do begin
      tick;
      lat++;
    end while (!(gnt0 || gnt1) && lat < 8);
    checkOutput("gnt_latency", 32'(lat), 32'd1);
    checkOutput("gnt0", 32'(gnt0), 32'(expId == 0));
    checkOutput("gnt1", 32'(gnt1), 32'(expId == 1));
    checkOutput("busy_norm", 32'(busy), 32'd1);
  endtask

  task automatic checkResult(input string tag, input int expId, input logic expSign, input res_t r);
    checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
    checkOutput({tag, "_id"}, 32'(outId), 32'(expId));
    checkOutput({tag, "_sign"}, 32'(outSign), 32'(expSign));
    checkOutput({tag, "_exp"}, 32'(outExp), 32'(r.e));
    checkOutput({tag, "_mant"}, 32'(outMant), 32'(r.m));
    checkOutput({tag, "_zero"}, 32'(outZero), 32'(r.zero));
    checkOutput({tag, "_ovf"}, 32'(outOvf), 32'(r.ovf));
    checkOutput({tag, "_unf"}, 32'(outUnf), 32'(r.unf));
    checkOutput({tag, "_nognt"}, 32'(gnt0 | gnt1), 32'd0);
  endtask

  task automatic finishOp;
    tick;
    checkOutput("valid_drop", 32'(outValid), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("no_gnt_on_accept", 32'(gnt0 | gnt1), 32'd0);
  endtask

  task automatic serveOne(input string tag, input int id, input logic [23:0] mant, input logic of,
                          input logic [7:0] ex, input logic sign, input res_t r);
    applyStimulus(id, 1'b1, mant, of, ex, sign);
    waitGrant(id);
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    tick;
    checkResult(tag, id, sign, r);
    finishOp;
  endtask

  logic        pend [2];
  logic [23:0] pM [2];
  logic        pOf [2];
  logic [7:0]  pE [2];
  logic        pS [2];
  int          lastRef;
  int          w;
  int          delay;
  int          sh;
  int          eSel;

  initial begin
    $display("[TB] starting norm_arbiter bench");
    tick;
    tick;
    checkOutput("rst_gnt0", 32'(gnt0), 32'd0);
    checkOutput("rst_gnt1", 32'(gnt1), 32'd0);
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_exp", 32'(outExp), 32'd0);
    checkOutput("rst_mant", 32'(outMant), 32'd0);
    checkOutput("rst_flags", 32'({outZero, outOvf, outUnf, outId, outSign}), 32'd0);
    reset = 1'b0;

    serveOne("hidden_only", 0, 24'h800000, 1'b0, 8'h80, 1'b0, mkRes(0, 0, 0, 8'h80, 23'h0));
    serveOne("lsb_only", 1, 24'h000001, 1'b0, 8'h80, 1'b1, mkRes(0, 0, 0, 8'h69, 23'h0));
    serveOne("underflow", 0, 24'h000100, 1'b0, 8'h05, 1'b0, mkRes(0, 0, 1, 8'h00, 23'h0));
    serveOne("overflow", 1, 24'hC00000, 1'b1, 8'hFE, 1'b1, mkRes(0, 1, 0, 8'hFF, 23'h0));
    serveOne("zero", 0, 24'h000000, 1'b0, 8'h40, 1'b1, mkRes(1, 0, 0, 8'h00, 23'h0));
    serveOne("carry_out", 1, 24'hC00001, 1'b1, 8'h10, 1'b0, mkRes(0, 0, 0, 8'h11, 23'h600000));
    serveOne("shift8", 0, 24'h00ABCD, 1'b0, 8'h80, 1'b0, mkRes(0, 0, 0, 8'h78, 23'h2BCD00));
    serveOne("exp_one", 1, 24'h400000, 1'b0, 8'h02, 1'b0, mkRes(0, 0, 0, 8'h01, 23'h0));
    serveOne("exp_254", 0, 24'hFFFFFF, 1'b1, 8'hFD, 1'b1, mkRes(0, 0, 0, 8'hFE, 23'h7FFFFF));

    // Both requesters held high: grants every 3 cycles, alternating from requester 0.
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    applyStimulus(0, 1'b1, 24'h800000, 1'b0, 8'h80, 1'b0);
    applyStimulus(1, 1'b1, 24'h400000, 1'b0, 8'h80, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      tick;
      checkOutput("rr_gnt0", 32'(gnt0), 32'((c % 3 == 1) && (((c - 1) / 3) % 2 == 0)));
      checkOutput("rr_gnt1", 32'(gnt1), 32'((c % 3 == 1) && (((c - 1) / 3) % 2 == 1)));
      checkOutput("rr_valid", 32'(outValid), 32'(c % 3 == 2));
      if (c % 3 == 2) begin
        checkOutput("rr_id", 32'(outId), 32'(((c - 2) / 3) % 2));
        checkOutput("rr_sign", 32'(outSign), 32'(((c - 2) / 3) % 2));
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Back-pressure: result must hold while a second request waits.
    outReady = 1'b0;
    applyStimulus(0, 1'b1, 24'h123456, 1'b0, 8'h90, 1'b1);
    waitGrant(0);
    req0 = 1'b0;
    applyStimulus(1, 1'b1, 24'h000F00, 1'b0, 8'h20, 1'b0);
    tick;
    checkResult("hold0", 0, 1'b1, mkRes(0, 0, 0, 8'h8D, 23'h11A2B0));
    for (int i = 1; i <= 4; i++) begin
      tick;
      checkResult("hold_stable", 0, 1'b1, mkRes(0, 0, 0, 8'h8D, 23'h11A2B0));
      checkOutput("hold_busy", 32'(busy), 32'd1);
    end
    outReady = 1'b1;
    finishOp;
    waitGrant(1);
    req1 = 1'b0;
    tick;
    checkResult("pending1", 1, 1'b0, mkRes(0, 0, 0, 8'h14, 23'h700000));
    finishOp;

    // Reset during NORM discards the operation and re-seeds the tie winner.
    applyStimulus(0, 1'b1, 24'h800000, 1'b0, 8'h33, 1'b0);
    waitGrant(0);
    reset = 1'b1;
    req0 = 1'b0;
    tick;
    checkOutput("abort_valid", 32'(outValid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_gnt", 32'(gnt0 | gnt1), 32'd0);
    reset = 1'b0;
    applyStimulus(0, 1'b1, 24'h000003, 1'b0, 8'h40, 1'b0);
    applyStimulus(1, 1'b1, 24'h800000, 1'b0, 8'h40, 1'b1);
    waitGrant(0);
    checkOutput("abort_no_result", 32'(outValid), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    checkResult("after_abort", 0, 1'b0, mkRes(0, 0, 0, 8'h2A, 23'h400000));
    finishOp;

    // Random traffic; a losing requester keeps its request and operands pending.
    lastRef = 0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int it = 0; it < 60; it++) begin
      for (int id = 0; id < 2; id++) begin
        if (!pend[id] && $urandom_range(0, 1) == 1) pend[id] = 1'b1;
        else continue;
        sh = $urandom_range(0, 24);
        pM[id] = 24'($urandom) >> sh;
        pOf[id] = ($urandom_range(0, 3) == 0);
        eSel = $urandom_range(0, 3);
        pE[id] = (eSel == 0) ? 8'($urandom_range(0, 25)) :
                 (eSel == 1) ? 8'($urandom_range(230, 255)) : 8'($urandom);
        pS[id] = 1'($urandom);
        applyStimulus(id, 1'b1, pM[id], pOf[id], pE[id], pS[id]);
      end
      if (!pend[0] && !pend[1]) begin
        w = $urandom_range(0, 1);
        pend[w] = 1'b1;
        pM[w] = 24'($urandom);
        pOf[w] = 1'b0;
        pE[w] = 8'($urandom);
        pS[w] = 1'($urandom);
        applyStimulus(w, 1'b1, pM[w], pOf[w], pE[w], pS[w]);
      end
      w = (pend[0] && pend[1]) ? 1 - lastRef : (pend[1] ? 1 : 0);
      lastRef = w;
      delay = $urandom_range(0, 2);
      outReady = (delay == 0);
      waitGrant(w);
      if (w == 0) req0 = 1'b0; else req1 = 1'b0;
      pend[w] = 1'b0;
      tick;
      checkResult("rand", w, pS[w], refNorm(pM[w], pOf[w], pE[w]));
      for (int k = 0; k < delay; k++) begin
        tick;
        checkOutput("rand_hold_valid", 32'(outValid), 32'd1);
      end
      outReady = 1'b1;
      finishOp;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
